// File: rtl/frame_buf_writer_pkg.sv
// -----------------------------------------------------------------------------
// frame_buf_writer_pkg
// Shared definitions for the frame buffer write path: default image geometry,
// FSM state encoding and the frame pixel count helper.
// -----------------------------------------------------------------------------
package frame_buf_writer_pkg;

  localparam int unsigned IMG_W_DEF  = 200;
  localparam int unsigned IMG_H_DEF  = 200;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } fbw_state_e;

  // Number of pixels in one frame.
  function automatic int unsigned frame_pix(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

endpackage

// File: rtl/frame_buf_writer_if.sv
// -----------------------------------------------------------------------------
// frame_buf_writer_if
// Pixel stream in / RAM write port out of the frame buffer writer.
//  capture_en, frame_start, pix_valid, pix_data : pixel source -> writer
//  ram_we, ram_waddr, ram_wdata                  : writer -> RAM write port
//  busy, frame_done, err_short                   : writer status
// master = pixel source / RAM side, slave = frame_buf_writer.
// -----------------------------------------------------------------------------
interface frame_buf_writer_if
  import frame_buf_writer_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic              capture_en;
  logic              frame_start;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              busy;
  logic              frame_done;
  logic              err_short;

  modport master (
    output capture_en, frame_start, pix_valid, pix_data,
    input  ram_we, ram_waddr, ram_wdata, busy, frame_done, err_short
  );

  modport slave (
    input  capture_en, frame_start, pix_valid, pix_data,
    output ram_we, ram_waddr, ram_wdata, busy, frame_done, err_short
  );

endinterface

// File: rtl/fbw_pix_counter.sv
// -----------------------------------------------------------------------------
// fbw_pix_counter
// Raster position tracker (x, y, linear address) for the frame writer.
//  clk, rst      : clock, async active-high reset
//  i_clr         : restart at pixel 0 (applies to this cycle's pixel)
//  i_inc         : a pixel is consumed this cycle
//  o_addr_c      : address of the pixel presented this cycle
//  o_last_pix_c  : the pixel presented this cycle is the last of the frame
// -----------------------------------------------------------------------------
module fbw_pix_counter
  import frame_buf_writer_pkg::*;
#(
  parameter int unsigned IMG_W  = IMG_W_DEF,
  parameter int unsigned IMG_H  = IMG_H_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_addr_c,
  output logic              o_last_pix_c
);

  localparam int unsigned X_W       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned Y_W       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned LAST_ADDR = frame_pix(IMG_W, IMG_H) - 1;

  logic [X_W-1:0]    r_x, w_x_cur, w_x_nxt;
  logic [Y_W-1:0]    r_y, w_y_cur, w_y_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_cur, w_addr_nxt;

  // Current position (clear takes effect for this cycle's pixel) and next position.
  always_comb begin
    w_x_cur    = i_clr ? '0 : r_x;
    w_y_cur    = i_clr ? '0 : r_y;
    w_addr_cur = i_clr ? '0 : r_addr;
    w_x_nxt    = w_x_cur;
    w_y_nxt    = w_y_cur;
    w_addr_nxt = w_addr_cur;
    if (i_inc) begin
      if (w_addr_cur == ADDR_W'(LAST_ADDR)) begin
        // Park at 0 after the final pixel so the address never runs past the buffer.
        w_x_nxt    = '0;
        w_y_nxt    = '0;
        w_addr_nxt = '0;
      end else if (w_x_cur == X_W'(IMG_W - 1)) begin
        w_x_nxt    = '0;
        w_y_nxt    = w_y_cur + Y_W'(1);
        w_addr_nxt = w_addr_cur + ADDR_W'(1);
      end else begin
        w_x_nxt    = w_x_cur + X_W'(1);
        w_addr_nxt = w_addr_cur + ADDR_W'(1);
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
    end else begin
      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
      r_addr <= w_addr_nxt;
    end
  end

  assign o_addr_c     = w_addr_cur;
  assign o_last_pix_c = (w_x_cur == X_W'(IMG_W - 1)) && (w_y_cur == Y_W'(IMG_H - 1));

endmodule

// File: rtl/frame_buf_writer.sv
// -----------------------------------------------------------------------------
// frame_buf_writer
// Stores one IMG_W x IMG_H frame of a valid-strobed pixel stream into the
// display RAM in raster order (address = y*IMG_W + x), one-cycle write latency.
//  clk  : system clock
//  rst  : asynchronous reset, active-high
//  bus  : frame_buf_writer_if.slave (pixel stream in, RAM write port and
//         busy / frame_done / err_short status out, all registered)
// -----------------------------------------------------------------------------
module frame_buf_writer
  import frame_buf_writer_pkg::*;
#(
  parameter int unsigned IMG_W  = IMG_W_DEF,
  parameter int unsigned IMG_H  = IMG_H_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input logic                clk,
  input logic                rst,
  frame_buf_writer_if.slave  bus
);

  fbw_state_e        r_state, w_state_nxt;
  logic              r_we, w_we;
  logic [ADDR_W-1:0] r_waddr, w_waddr;
  logic [DATA_W-1:0] r_wdata, w_wdata;
  logic              r_busy;
  logic              r_frame_done, w_frame_done;
  logic              r_err_short, w_err_short;
  logic              w_clr, w_inc, w_accept;
  logic [ADDR_W-1:0] w_addr_c;
  logic              w_last_c;

  fbw_pix_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_pix_counter (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_clr),
    .i_inc        (w_inc),
    .o_addr_c     (w_addr_c),
    .o_last_pix_c (w_last_c)
  );

  // Next state and next output values.
  always_comb begin
    w_state_nxt  = r_state;
    w_we         = 1'b0;
    w_waddr      = r_waddr;
    w_wdata      = r_wdata;
    w_frame_done = 1'b0;
    w_err_short  = r_err_short;
    w_clr        = 1'b0;
    w_inc        = 1'b0;
    w_accept     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.frame_start && bus.capture_en) begin
          w_state_nxt = ST_CAPTURE;
          w_clr       = 1'b1;
          w_accept    = 1'b1;
        end
      end
      ST_CAPTURE: begin
        w_accept = 1'b1;
        // A new frame_start mid-frame restarts the frame and is flagged.
        if (bus.frame_start) begin
          w_clr       = 1'b1;
          w_err_short = 1'b1;
        end
      end
      ST_DONE: begin
        w_frame_done = 1'b1;
        w_state_nxt  = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // A pixel accepted together with frame_start is pixel 0 of the new frame.
    if (w_accept && bus.pix_valid) begin
      w_inc   = 1'b1;
      w_we    = 1'b1;
      w_waddr = w_addr_c;
      w_wdata = bus.pix_data;
      if (w_last_c) begin
        w_state_nxt = ST_DONE;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_err_short  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_we         <= w_we;
      r_waddr      <= w_waddr;
      r_wdata      <= w_wdata;
      r_busy       <= (w_state_nxt == ST_CAPTURE);
      r_frame_done <= w_frame_done;
      r_err_short  <= w_err_short;
    end
  end

  assign bus.ram_we     = r_we;
  assign bus.ram_waddr  = r_waddr;
  assign bus.ram_wdata  = r_wdata;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;
  assign bus.err_short  = r_err_short;

endmodule
